// File: rtl/mem_access_stage.sv
// MEM stage of the 8-bit pipelined MIPS datapath: data memory, optional wait states and stall.
// Define DMEM_PERF_CNT_EN to build the load/store/stall performance counters.
module mem_access_stage #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        MemtoReg,
  input  logic        RegWrite,
  input  logic [7:0]  alu_result,
  input  logic [7:0]  write_data,
  output logic        stall,
  output logic [7:0]  alu_result_out,
  output logic [7:0]  data_mem_dout,
  output logic        RegWrite_out,
  output logic        MemtoReg_out,
  output logic [15:0] load_count,
  output logic [15:0] store_count,
  output logic [15:0] stall_count
);

  localparam int unsigned Depth   = 1 << ADDR_W;
  localparam logic [3:0]  WsMax   = 4'(WAIT_STATES);
  localparam bit          HasWait = (WAIT_STATES != 0);

  typedef enum logic {StIdle, StWait} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  lat_alu_q, lat_wdata_q;
  logic        lat_rd_q, lat_wr_q, lat_regwrite_q, lat_memtoreg_q;
  logic [7:0]  mem [Depth];

  logic              access, accept, complete, done_rd, done_wr;
  logic [7:0]        cur_alu, cur_wdata;
  logic              cur_rd, cur_wr, cur_regwrite, cur_memtoreg;
  logic [ADDR_W-1:0] cur_addr;

  assign access = MemRead | MemWrite;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    stall        = 1'b0;
    accept       = 1'b0;
    complete     = 1'b0;
    cur_alu      = alu_result;
    cur_wdata    = write_data;
    cur_rd       = MemRead;
    cur_wr       = MemWrite;
    cur_regwrite = RegWrite;
    cur_memtoreg = MemtoReg;
    unique case (state_q)
      StIdle: begin
        if (access) begin
          if (HasWait) begin
            stall   = 1'b1;
            accept  = 1'b1;
            cnt_d   = 4'd1;
            state_d = StWait;
          end else begin
            complete = 1'b1;
          end
        end
      end
      StWait: begin
        // Inputs are frozen upstream but ignored anyway; the latched op drives everything.
        cur_alu      = lat_alu_q;
        cur_wdata    = lat_wdata_q;
        cur_rd       = lat_rd_q;
        cur_wr       = lat_wr_q;
        cur_regwrite = lat_regwrite_q;
        cur_memtoreg = lat_memtoreg_q;
        if (cnt_q != WsMax) begin
          stall = 1'b1;
          cnt_d = cnt_q + 4'd1;
        end else begin
          complete = 1'b1;
          cnt_d    = 4'd0;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign cur_addr       = cur_alu[ADDR_W-1:0];
  assign done_wr        = complete & cur_wr;
  assign done_rd        = complete & cur_rd & ~cur_wr;
  assign alu_result_out = cur_alu;
  assign data_mem_dout  = mem[cur_addr];
  assign RegWrite_out   = cur_regwrite & ~stall;
  assign MemtoReg_out   = cur_memtoreg & ~stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      cnt_q          <= 4'd0;
      lat_alu_q      <= 8'd0;
      lat_wdata_q    <= 8'd0;
      lat_rd_q       <= 1'b0;
      lat_wr_q       <= 1'b0;
      lat_regwrite_q <= 1'b0;
      lat_memtoreg_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        lat_alu_q      <= alu_result;
        lat_wdata_q    <= write_data;
        lat_rd_q       <= MemRead;
        lat_wr_q       <= MemWrite;
        lat_regwrite_q <= RegWrite;
        lat_memtoreg_q <= MemtoReg;
      end
    end
  end

  // Contents survive reset; reset only blocks a write committing on the same edge.
  always_ff @(posedge clk) begin
    if (!reset && done_wr) begin
      mem[cur_addr] <= cur_wdata;
    end
  end

`ifdef DMEM_PERF_CNT_EN
  logic [15:0] load_q, store_q, stall_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      load_q  <= 16'd0;
      store_q <= 16'd0;
      stall_q <= 16'd0;
    end else begin
      if (done_rd && load_q != 16'hFFFF)  load_q  <= load_q + 16'd1;
      if (done_wr && store_q != 16'hFFFF) store_q <= store_q + 16'd1;
      if (stall && stall_q != 16'hFFFF)   stall_q <= stall_q + 16'd1;
    end
  end

  assign load_count  = load_q;
  assign store_count = store_q;
  assign stall_count = stall_q;
`else
  assign load_count  = 16'd0;
  assign store_count = 16'd0;
  assign stall_count = 16'd0;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: four instances with WAIT_STATES 0..3 side by side.
module tb_mem_access_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [4];
  logic        mr [4], mw [4], m2r [4], rw [4];
  logic [7:0]  alu [4], wd [4];
  logic        stall_o [4], rw_o [4], m2r_o [4];
  logic [7:0]  alu_o [4], dout_o [4];
  logic [15:0] ld_cnt [4], st_cnt [4], sl_cnt [4];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    mem_access_stage #(
      .ADDR_W      (8),
      .WAIT_STATES (g)
    ) u_dut (
      .clk            (clk),
      .reset          (rst[g]),
      .MemRead        (mr[g]),
      .MemWrite       (mw[g]),
      .MemtoReg       (m2r[g]),
      .RegWrite       (rw[g]),
      .alu_result     (alu[g]),
      .write_data     (wd[g]),
      .stall          (stall_o[g]),
      .alu_result_out (alu_o[g]),
      .data_mem_dout  (dout_o[g]),
      .RegWrite_out   (rw_o[g]),
      .MemtoReg_out   (m2r_o[g]),
      .load_count     (ld_cnt[g]),
      .store_count    (st_cnt[g]),
      .stall_count    (sl_cnt[g])
    );
  end

`ifdef DMEM_PERF_CNT_EN
  localparam bit PerfOn = 1'b1;
`else
  localparam bit PerfOn = 1'b0;
`endif

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input int k, input logic rd, input logic wr, input logic [7:0] addr,
                       input logic [7:0] data);
    mr[k]  = rd;
    mw[k]  = wr;
    rw[k]  = rd & ~wr;
    m2r[k] = rd & ~wr;
    alu[k] = addr;
    wd[k]  = data;
  endtask

  // One full access on instance k (WAIT_STATES == k); exp_dout checked at completion for reads.
  task automatic access(input int k, input logic rd, input logic wr, input logic [7:0] addr,
                        input logic [7:0] wdata, input logic [7:0] exp_dout, input string tag);
    for (int c = 0; c <= k; c++) begin
      @(negedge clk);
      if (c == 0) drive(k, rd, wr, addr, wdata);
      else        drive(k, 1'b0, 1'b0, 8'h00, 8'h00);
      #1;
      check_eq({tag, "_stall"}, 16'(stall_o[k]), 16'(c < k));
      check_eq({tag, "_rwout"}, 16'(rw_o[k]), (c == k) ? 16'(rd & ~wr) : 16'd0);
      if (c == k) begin
        check_eq({tag, "_aluout"}, 16'(alu_o[k]), 16'(addr));
        check_eq({tag, "_m2rout"}, 16'(m2r_o[k]), 16'(rd & ~wr));
        if (rd) check_eq({tag, "_dout"}, 16'(dout_o[k]), 16'(exp_dout));
      end
    end
    @(negedge clk);
    drive(k, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic check_cnt(input int k, input string tag, input int ld, input int st,
                           input int sl);
    check_eq({tag, "_loads"},  ld_cnt[k], PerfOn ? 16'(ld) : 16'd0);
    check_eq({tag, "_stores"}, st_cnt[k], PerfOn ? 16'(st) : 16'd0);
    check_eq({tag, "_stalls"}, sl_cnt[k], PerfOn ? 16'(sl) : 16'd0);
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      rst[k] = 1'b1;
      drive(k, 1'b0, 1'b0, 8'h00, 8'h00);
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) rst[k] = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("rst_stall%0d", k), 16'(stall_o[k]), 16'd0);
      check_cnt(k, $sformatf("rst_cnt%0d", k), 0, 0, 0);
    end

    // WAIT_STATES=0: store then load, same-cycle data, never stalls
    access(0, 1'b0, 1'b1, 8'h10, 8'hA5, 8'h00, "ws0_st");
    access(0, 1'b1, 1'b0, 8'h10, 8'h00, 8'hA5, "ws0_ld");
    check_cnt(0, "ws0_cnt", 1, 1, 0);

    // WAIT_STATES=3: preload then 3 stall cycles before the data
    access(3, 1'b0, 1'b1, 8'h20, 8'h3C, 8'h00, "ws3_st");
    access(3, 1'b1, 1'b0, 8'h20, 8'h00, 8'h3C, "ws3_ld");
    check_cnt(3, "ws3_cnt", 1, 1, 6);

    // WAIT_STATES=1: read+write is a store that shows pre-write data
    access(1, 1'b0, 1'b1, 8'h40, 8'h11, 8'h00, "ws1_pre");
    access(1, 1'b1, 1'b1, 8'h40, 8'h22, 8'h11, "ws1_both");
    check_cnt(1, "ws1_both_cnt", 0, 2, 2);
    access(1, 1'b1, 1'b0, 8'h40, 8'h00, 8'h22, "ws1_ld");
    check_cnt(1, "ws1_cnt", 1, 2, 3);

    // WAIT_STATES=2: preload, then reset in the second stall cycle of a store
    access(2, 1'b0, 1'b1, 8'h05, 8'h5A, 8'h00, "ws2_p05");
    access(2, 1'b0, 1'b1, 8'h30, 8'hC3, 8'h00, "ws2_p30");
    access(2, 1'b0, 1'b1, 8'h31, 8'h3D, 8'h00, "ws2_p31");
    @(negedge clk); drive(2, 1'b0, 1'b1, 8'h05, 8'h77); #1;
    check_eq("ws2_rst_acc_stall", 16'(stall_o[2]), 16'd1);
    @(negedge clk); rst[2] = 1'b1; #1;
    check_eq("ws2_rst_wait_stall", 16'(stall_o[2]), 16'd1);
    @(negedge clk); rst[2] = 1'b0; drive(2, 1'b0, 1'b0, 8'h00, 8'h00); #1;
    check_eq("ws2_after_rst_stall", 16'(stall_o[2]), 16'd0);
    check_cnt(2, "ws2_rst_cnt", 0, 0, 0);

    // Back-to-back loads; address change to 8'h99 during WAIT is ignored
    @(negedge clk); drive(2, 1'b1, 1'b0, 8'h30, 8'h00); #1;
    check_eq("b2b_a0_stall", 16'(stall_o[2]), 16'd1);
    check_eq("b2b_a0_rwout", 16'(rw_o[2]), 16'd0);
    @(negedge clk); drive(2, 1'b1, 1'b0, 8'h99, 8'h00); #1;
    check_eq("b2b_a1_stall", 16'(stall_o[2]), 16'd1);
    @(negedge clk); #1;
    check_eq("b2b_a2_stall", 16'(stall_o[2]), 16'd0);
    check_eq("b2b_a2_dout", 16'(dout_o[2]), 16'h00C3);
    check_eq("b2b_a2_aluout", 16'(alu_o[2]), 16'h0030);
    check_eq("b2b_a2_rwout", 16'(rw_o[2]), 16'd1);
    @(negedge clk); drive(2, 1'b1, 1'b0, 8'h31, 8'h00); #1;
    check_eq("b2b_b0_stall", 16'(stall_o[2]), 16'd1);
    @(negedge clk); drive(2, 1'b0, 1'b0, 8'h00, 8'h00); #1;
    check_eq("b2b_b1_stall", 16'(stall_o[2]), 16'd1);
    @(negedge clk); #1;
    check_eq("b2b_b2_stall", 16'(stall_o[2]), 16'd0);
    check_eq("b2b_b2_dout", 16'(dout_o[2]), 16'h003D);
    check_eq("b2b_b2_aluout", 16'(alu_o[2]), 16'h0031);
    @(negedge clk); #1;
    check_eq("b2b_idle_stall", 16'(stall_o[2]), 16'd0);
    check_cnt(2, "b2b_cnt", 2, 0, 4);

    // Aborted store must not have reached 8'h05
    access(2, 1'b1, 1'b0, 8'h05, 8'h00, 8'h5A, "ws2_chk05");
    check_cnt(2, "ws2_cnt", 3, 0, 6);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access (MEM) stage of the 8-bit pipelined MIPS datapath. It sits between the EX/MEM pipeline register and the MEM/WB pipeline register. It owns the 256×8 data memory, performs loads and stores addressed by the ALU result, and inserts a configurable number of wait states, stalling the upstream pipeline while it does so. Its outputs (`alu_result_out`, `data_mem_dout`, `RegWrite_out`, `MemtoReg_out`) connect directly to the MEM/WB register inputs of the same names.

## Interface
- `ADDR_W`, 8: data memory address width; depth is 2^ADDR_W bytes.
- `WAIT_STATES`, 0: extra cycles per memory access (legal range 0..15).

- `clk` input 1: the single clock; all state changes on the rising edge.
- `reset` input 1: synchronous, active-high reset, sampled on the rising edge of `clk`.
- `MemRead` input 1: load request from EX/MEM.
- `MemWrite` input 1: store request from EX/MEM.
- `MemtoReg` input 1: writeback select from EX/MEM; passed through.
- `RegWrite` input 1: register write enable from EX/MEM; passed through.
- `alu_result` input 8: memory address (low ADDR_W bits) and ALU value to forward.
- `write_data` input 8: store data.
- `stall` output 1: freeze PC, IF/ID, ID/EX and EX/MEM while high.
- `alu_result_out` output 8: ALU result to MEM/WB.
- `data_mem_dout` output 8: load data to MEM/WB.
- `RegWrite_out`, `MemtoReg_out` output 1 each: control to MEM/WB.
- `load_count`, `store_count`, `stall_count` output 16 each: performance counters (see Configuration).

## Operation
- An access is any cycle in which `MemRead | MemWrite` is high in IDLE.
- If `MemRead` and `MemWrite` are both high, the access is a store. `data_mem_dout` shows the pre-write contents.
- FSM states:
  - IDLE:
    - With no access, or with WAIT_STATES=0: outputs are combinational from the inputs and `stall`=0. A store commits at this rising edge. A load returns `mem[addr]` combinationally.
    - With an access and WAIT_STATES>0: latch `alu_result`, `write_data`, the op, `RegWrite` and `MemtoReg`. Assert `stall`=1, set `cnt`=1, go to WAIT.
  - WAIT: outputs come from the latched values.
    - If `cnt`≠WAIT_STATES: `stall`=1 and `cnt`++.
    - If `cnt`=WAIT_STATES: `stall`=0 (completion cycle). `data_mem_dout`=`mem[latched addr]`, a latched store commits at this edge, and the next state is IDLE.
- Input changes during WAIT are ignored; the latched values rule.
- While `stall`=1, `RegWrite_out` and `MemtoReg_out` are forced to 0, so MEM/WB captures a bubble. `alu_result_out` and `data_mem_dout` are don't-care in those cycles.
- Address uses the low ADDR_W bits of `alu_result`; upper bits are ignored, giving wrap-around.
- Memory contents are not cleared by reset. Bench must preload or write before reading.

## Timing
- Reset values: state=IDLE, `cnt`=0, `stall`=0, all latches 0, counters 0.
- The combinational outputs follow the inputs in IDLE.
- Access latency is WAIT_STATES+1 cycles from acceptance to completion.
  - `stall` is high for exactly WAIT_STATES cycles, starting in the acceptance cycle.
  - Completion falls in cycle t+WAIT_STATES.
- Back-to-back accesses: the next access can be accepted in the cycle after completion (t+WAIT_STATES+1). There is no dead cycle.
- Reset during WAIT: the access is abandoned, no write is committed, the block returns to IDLE and `stall`=0 next cycle.
- A non-memory instruction (no access) never stalls, in any state transition.

## Configuration
- `DMEM_PERF_CNT_EN` defined:
  - `load_count` increments on each completed load.
  - `store_count` increments on each completed store.
  - `stall_count` increments each cycle `stall`=1.
  - All three are 16-bit, saturate at 16'hFFFF, and clear on `reset`.
- `DMEM_PERF_CNT_EN` not defined: the three ports exist and are tied to 0, and no counter logic is built.

## Test plan
- WAIT_STATES=0: store `write_data`=8'hA5 to addr 8'h10, then load addr 8'h10 → `data_mem_dout`=8'hA5 in the same cycle, `stall` never asserted.
- WAIT_STATES=3: load from addr 8'h20 (preloaded 8'h3C) → `stall`=1 for 3 cycles with `RegWrite_out`=0, then 1 cycle `stall`=0 with `data_mem_dout`=8'h3C and `RegWrite_out`=1.
- WAIT_STATES=2, reset asserted in the second stall cycle of a store of 8'h77 to 8'h05 → addr 8'h05 unchanged, `stall`=0 the cycle after reset.
- WAIT_STATES=1: `MemRead`=`MemWrite`=1, addr 8'h40 holding 8'h11, data 8'h22 → completion `data_mem_dout`=8'h11; a later load returns 8'h22; `store_count`+1 and `load_count` unchanged (macro on).
- WAIT_STATES=2, inputs changed to addr 8'h99 during WAIT → access completes on the originally latched address. Two back-to-back loads take exactly 6 cycles total, and `stall_count`=4.
- Macro off: run any traffic → `load_count`, `store_count` and `stall_count` stay 0.
